// File: rtl/s5_seq_ctrl_pkg.sv
// Shared definitions for the sequenced divide controller.
package s5_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DIV_AB,
    CHECK,
    DIV_CD,
    DONE
  } state_t;

  // Quotient reported for a zero divisor (sliced to the operand width).
  localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/s5_seq_ctrl_sdiv_iter.sv
// Iterative signed divider: restoring division on magnitudes, one quotient
// bit per clock, sign fix-up applied on the outputs.
module sdiv_iter
  import s5_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic [DATAWIDTH-1:0] quotient,
  output logic [DATAWIDTH-1:0] remainder,
  output logic                 dbz,
  output logic                 ready
);

  logic [DATAWIDTH-1:0] q_r, rem_r, dmag_r;
  logic [DATAWIDTH-1:0] mag_a, mag_b;
  logic [DATAWIDTH:0]   trial;
  logic                 negq_r, negr_r, dbz_r, run_r;
  logic [6:0]           cnt_r;

  always_comb begin
    mag_a = dividend[DATAWIDTH-1] ? -dividend : dividend;
    mag_b = divisor[DATAWIDTH-1]  ? -divisor  : divisor;
    // Borrow out of the top bit means the trial subtraction went negative.
    trial = {rem_r, q_r[DATAWIDTH-1]} - {1'b0, dmag_r};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r    <= '0;
      rem_r  <= '0;
      dmag_r <= '0;
      negq_r <= 1'b0;
      negr_r <= 1'b0;
      dbz_r  <= 1'b0;
      run_r  <= 1'b0;
      cnt_r  <= '0;
    end else if (load) begin
      q_r    <= mag_a;
      rem_r  <= '0;
      dmag_r <= mag_b;
      negq_r <= dividend[DATAWIDTH-1] ^ divisor[DATAWIDTH-1];
      negr_r <= dividend[DATAWIDTH-1];
      dbz_r  <= (divisor == '0);
      run_r  <= 1'b1;
      cnt_r  <= 7'(DATAWIDTH);
    end else if (run_r) begin
      if (!trial[DATAWIDTH]) rem_r <= trial[DATAWIDTH-1:0];
      else                   rem_r <= {rem_r[DATAWIDTH-2:0], q_r[DATAWIDTH-1]};
      q_r   <= {q_r[DATAWIDTH-2:0], ~trial[DATAWIDTH]};
      cnt_r <= cnt_r - 7'd1;
      if (cnt_r == 7'd1) run_r <= 1'b0;
    end
  end

  always_comb begin
    if (dbz_r)       quotient = DBZ_QUOTIENT[DATAWIDTH-1:0];
    else if (negq_r) quotient = -q_r;
    else             quotient = q_r;
    remainder = negr_r ? -rem_r : rem_r;
    dbz       = dbz_r;
    ready     = ~run_r;
  end

endmodule

// File: rtl/s5_seq_ctrl.sv
// Sequencer computing z = ((a mod b) == zero) ? a/b : c/d with one shared
// iterative signed divider.
module s5_seq_ctrl
  import s5_seq_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] z,
  output logic                 dbz
);

  state_t               state;
  logic [DATAWIDTH-1:0] c_r, d_r, zero_r;
  logic [6:0]           step;

  logic                 div_load, div_dbz, div_ready;
  logic [DATAWIDTH-1:0] div_dividend, div_divisor, div_q, div_rem;

  always_comb begin
    div_load     = ((state == IDLE) && start) || ((state == CHECK) && (div_rem != zero_r));
    div_dividend = (state == IDLE) ? a : c_r;
    div_divisor  = (state == IDLE) ? b : d_r;
  end

  sdiv_iter #(.DATAWIDTH(DATAWIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (div_dividend),
    .divisor   (div_divisor),
    .quotient  (div_q),
    .remainder (div_rem),
    .dbz       (div_dbz),
    .ready     (div_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      z      <= '0;
      dbz    <= 1'b0;
      c_r    <= '0;
      d_r    <= '0;
      zero_r <= '0;
      step   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= DIV_AB;
            busy   <= 1'b1;
            c_r    <= c;
            d_r    <= d;
            zero_r <= zero;
            step   <= '0;
          end
        end
        // Leaves on the last iteration edge so CHECK sees the finished a/b;
        // DIV_CD instead waits one edge for ready, matching the longer path.
        DIV_AB: begin
          step <= step + 7'd1;
          if (step == 7'(DATAWIDTH - 1)) state <= CHECK;
        end
        CHECK: begin
          if (div_rem == zero_r) begin
            state <= DONE;
            z     <= div_q;
            dbz   <= div_dbz;
            done  <= 1'b1;
          end else begin
            state <= DIV_CD;
          end
        end
        DIV_CD: begin
          if (div_ready) begin
            state <= DONE;
            z     <= div_q;
            dbz   <= div_dbz;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s5_seq_ctrl.sv
// Scoreboard bench for s5_seq_ctrl: stimulus queues expected results, a
// monitor compares them whenever done is presented.
module tb_s5_seq_ctrl;

  localparam int unsigned W = 64;

  typedef struct {
    logic [W-1:0] z;
    logic         dbz;
    int unsigned  cyc;
    string        name;
  } exp_t;

  logic         clk, rst, start;
  logic [W-1:0] a, b, c, d, zero;
  logic         busy, done, dbz;
  logic [W-1:0] z;

  exp_t        sb[$];
  int unsigned cyc;
  int          checks, errors;

  s5_seq_ctrl #(.DATAWIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .zero  (zero),
    .busy  (busy),
    .done  (done),
    .z     (z),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=z:%0h cyc:%0d required=no done", z, cyc);
        end else begin
          e = sb.pop_front();
          check({e.name, "_z"}, z, e.z);
          check({e.name, "_dbz"}, {{(W-1){1'b0}}, dbz}, {{(W-1){1'b0}}, e.dbz});
          check({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
        end
      end
    end
  endtask

  // Drives a one-cycle start; k is the edge number that samples it.
  task automatic issue(input string name, input logic [W-1:0] ta, tb_, tc, td, tz,
                       input logic [W-1:0] ez, input logic edbz, input int unsigned lat,
                       input bit push, output int unsigned k);
    exp_t e;
    @(negedge clk);
    a = ta; b = tb_; c = tc; d = td; zero = tz;
    start = 1'b1;
    k = cyc + 1;
    if (push) begin
      e.z = ez; e.dbz = edbz; e.cyc = k + lat; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int unsigned n;
    n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
      n++;
      if (n > 300) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout actual=no done required=done within 300 cycles", name);
        sb.delete();
        break;
      end
    end
  endtask

  initial begin
    int unsigned k;
    checks = 0; errors = 0;
    rst = 1'b0; start = 1'b0;
    a = '0; b = '0; c = '0; d = '0; zero = '0;
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check("reset_busy", {{(W-1){1'b0}}, busy}, '0);
    check("reset_done", {{(W-1){1'b0}}, done}, '0);
    check("reset_z", z, '0);
    check("reset_dbz", {{(W-1){1'b0}}, dbz}, '0);
    rst = 1'b1;

    issue("eq_path", 64'd20, 64'd5, 64'd9, 64'd3, 64'd0, 64'd4, 1'b0, 65, 1'b1, k);
    wait_idle("eq_path");
    issue("neq_path", 64'd7, 64'd2, -64'sd9, 64'd2, 64'd0, -64'sd4, 1'b0, 130, 1'b1, k);
    wait_idle("neq_path");
    issue("b_zero", 64'd5, 64'd0, 64'd1, 64'd1, 64'd5, '1, 1'b1, 65, 1'b1, k);
    wait_idle("b_zero");
    issue("most_neg", 64'h8000_0000_0000_0000, '1, 64'd1, 64'd1, 64'd0,
          64'h8000_0000_0000_0000, 1'b0, 65, 1'b1, k);
    wait_idle("most_neg");
    issue("neg_rem_eq", -64'sd7, 64'd2, 64'd1, 64'd1, '1, -64'sd3, 1'b0, 65, 1'b1, k);
    wait_idle("neg_rem_eq");
    issue("rem_sign", -64'sd7, 64'd2, -64'sd8, -64'sd2, 64'd1, 64'd4, 1'b0, 130, 1'b1, k);
    wait_idle("rem_sign");
    issue("d_zero", 64'd7, 64'd2, -64'sd9, 64'd0, 64'd0, '1, 1'b1, 130, 1'b1, k);
    wait_idle("d_zero");
    issue("ab_dbz_dropped", 64'd5, 64'd0, 64'd10, 64'd3, 64'd0, 64'd3, 1'b0, 130, 1'b1, k);
    wait_idle("ab_dbz_dropped");

    // Start while busy plus operand changes after capture must be ignored.
    issue("ignore_start", 64'd20, 64'd5, 64'd9, 64'd3, 64'd0, 64'd4, 1'b0, 65, 1'b1, k);
    while (cyc != k + 9) @(negedge clk);
    a = 64'd100; b = 64'd3; c = 64'd50; d = 64'd7; zero = 64'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 64'd11; b = 64'd0; c = 64'd13; d = 64'd0; zero = 64'd2;
    wait_idle("ignore_start");

    // Back-to-back: start issued in the IDLE cycle right after DONE.
    issue("back2back", 64'd100, 64'd7, 64'd1, 64'd1, 64'd2, 64'd14, 1'b0, 65, 1'b1, k);
    wait_idle("back2back");

    // Reset mid DIV_AB: outputs clear at once, no result is emitted.
    issue("aborted", 64'd99, 64'd3, 64'd1, 64'd1, 64'd0, '0, 1'b0, 65, 1'b0, k);
    while (cyc != k + 39) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("midrst_z", z, '0);
    check("midrst_busy", {{(W-1){1'b0}}, busy}, '0);
    check("midrst_done", {{(W-1){1'b0}}, done}, '0);
    check("midrst_dbz", {{(W-1){1'b0}}, dbz}, '0);
    @(negedge clk);
    rst = 1'b1;
    issue("after_rst", 64'd20, 64'd5, 64'd9, 64'd3, 64'd0, 64'd4, 1'b0, 65, 1'b1, k);
    wait_idle("after_rst");

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s5_seq_ctrl.md
S5_SEQ_CTRL -- requirements
Module: s5_seq_ctrl

Interface
REQ-001 Parameter: DATAWIDTH, default 64, operand/result width in bits (legal range 4..64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a, b, c, d, zero  input  DATAWIDTH each  signed operands; captured on start acceptance.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle pulse; z valid.
REQ-008 z  output  DATAWIDTH  signed result register.
REQ-009 dbz  output  1  divide-by-zero flag for the last result; updated with z.

Function
REQ-010 The block SHALL compute z = ((a mod b) == zero) ? a/b : c/d, using one shared iterative signed divider for both divisions.
REQ-011 Division SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-012 Divisor 0 SHALL give quotient all-ones, remainder = dividend, and SHALL set dbz for that result.
REQ-013 Most-negative / -1 SHALL give quotient = most-negative (wrap) and remainder 0, with no flag.
REQ-014 FSM states: IDLE, DIV_AB, CHECK, DIV_CD, DONE.
REQ-015 IDLE: start=1 at edge k SHALL capture all operands, load the divider with a,b, and go to DIV_AB.
REQ-016 DIV_AB: one quotient bit per cycle for exactly DATAWIDTH cycles (edges k+1..k+DATAWIDTH), then go to CHECK.
REQ-017 CHECK: if remainder == zero, go to DONE with z <= quotient(a/b); otherwise load the divider with c,d and go to DIV_CD.
REQ-018 DIV_CD: DATAWIDTH iterations, then go to DONE with z <= quotient(c/d).
REQ-019 Latency: done SHALL be high in the cycle after edge k+DATAWIDTH+1 (equal path) or after edge k+2*DATAWIDTH+2 (unequal path).
REQ-020 DONE SHALL last exactly one cycle, assert done, then return to IDLE; back-to-back start is accepted the cycle after DONE.
REQ-021 start while busy SHALL be ignored and SHALL NOT alter captured operands.
REQ-022 z and dbz SHALL hold their value until the next DONE; operand changes after capture SHALL have no effect.
REQ-023 dbz SHALL reflect only the division whose quotient is loaded into z; a b==0 remainder SHALL still be compared (remainder = a).

Reset
REQ-024 rst low SHALL immediately force IDLE, z=0, dbz=0, done=0, busy=0, and clear the divider state, including mid-operation.
REQ-025 After rst rises, the first start SHALL be accepted on the next rising edge with normal latency; no partial result is ever output.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and the divide-by-zero quotient constant.
REQ-027 The iterative divider SHALL be a separate sub-module, sdiv_iter, with ports load, dividend, divisor, quotient, remainder, dbz, and ready.
REQ-028 sdiv_iter SHALL implement a magnitude restoring algorithm with sign fix-up and SHALL be reset by the same rst.

Verification (DATAWIDTH=64)
REQ-029 a=20, b=5, zero=0, c=9, d=3, start at edge k -> done at k+65, z=4, dbz=0.
REQ-030 a=7, b=2, zero=0, c=-9, d=2 -> remainder 1 takes the c/d path; done at k+130, z=-4.
REQ-031 a=5, b=0, zero=5 -> remainder 5 equals zero; z=all-ones, dbz=1, done at k+65.
REQ-032 a=-2^63, b=-1, zero=0 -> z=-2^63, dbz=0; then a=-7, b=2, zero=-1 -> z=-3.
REQ-033 Assert rst at edge k+40 mid-DIV_AB -> z=0 and busy=0 immediately; a new start gives a correct result with normal latency.
REQ-034 Pulse start again at k+10 with different operands -> ignored; the original result appears at k+65.
